bsg_cache_to_axi_rx: RTL and testbench

Read-side counterpart of the cache-to-AXI write path. It accepts block-read requests from num_cache_p caches, issues one AXI AR burst per block, and returns R-channel beats to the requesting cache as data_width_p words on its DMA data port. An in-order tag FIFO tracks outstanding requests and their cache IDs.

---
 rtl/bsg_cache_to_axi_rx_pkg.sv | 22 ++
 rtl/bsg_cache_to_axi_rx_piso.sv | 62 ++++++
 rtl/bsg_cache_to_axi_rx.sv | 144 ++++++++++++++
 tb/tb_bsg_cache_to_axi_rx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bsg_cache_to_axi_rx_pkg.sv
// AXI read-channel constant encodings and sizing helpers shared by the cache-to-AXI
// read and write paths.
package bsg_cache_to_axi_rx_pkg;

  localparam logic [1:0] AxiBurstFixed = 2'b00;
  localparam logic [1:0] AxiBurstIncr  = 2'b01;
  localparam logic [1:0] AxiBurstWrap  = 2'b10;

  localparam logic [3:0] AxiCacheDevNonBuf = 4'b0000;
  localparam logic [2:0] AxiProtDefault    = 3'b000;
  localparam logic       AxiLockNormal     = 1'b0;

  // Index width that never collapses to zero bits.
  function automatic int unsigned lg_f(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [2:0] axi_size_f(input int unsigned bytes);
    return 3'($clog2(bytes));
  endfunction

endpackage

// File: rtl/bsg_cache_to_axi_rx_piso.sv
// One-beat buffer that loads a wide R beat and hands it out one cache word at a time,
// low word first.
module bsg_cache_to_axi_rx_piso
  import bsg_cache_to_axi_rx_pkg::*;
#(
  parameter int unsigned in_width_p  = 32,
  parameter int unsigned out_width_p = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   load_i,
  input  logic [in_width_p-1:0]  data_i,
  input  logic                   yumi_i,
  output logic                   v_o,
  output logic [out_width_p-1:0] data_o,
  output logic                   last_o
);

  localparam int unsigned Els  = in_width_p / out_width_p;
  localparam int unsigned SelW = lg_f(Els);

  logic [in_width_p-1:0] data_q, data_d;
  logic                  v_q, v_d;
  logic [SelW-1:0]       sel_q, sel_d;

  assign v_o    = v_q;
  assign last_o = (sel_q == SelW'(Els - 1));
  assign data_o = data_q[int'(sel_q) * out_width_p +: out_width_p];

  // A load may coincide with the final word leaving; the new beat wins.
  always_comb begin
    data_d = data_q;
    v_d    = v_q;
    sel_d  = sel_q;
    if (yumi_i) begin
      if (last_o) begin
        v_d   = 1'b0;
        sel_d = '0;
      end else begin
        sel_d = sel_q + SelW'(1);
      end
    end
    if (load_i) begin
      data_d = data_i;
      v_d    = 1'b1;
      sel_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q <= '0;
      v_q    <= 1'b0;
      sel_q  <= '0;
    end else begin
      data_q <= data_d;
      v_q    <= v_d;
      sel_q  <= sel_d;
    end
  end

endmodule

// File: rtl/bsg_cache_to_axi_rx.sv
// Block-read path from several caches to one AXI read port: one AR burst per block,
// R beats serialized back to the owning cache in request order.
module bsg_cache_to_axi_rx
  import bsg_cache_to_axi_rx_pkg::*;
#(
  parameter int unsigned addr_width_p          = 28,
  parameter int unsigned data_width_p          = 32,
  parameter int unsigned block_size_in_words_p = 4,
  parameter int unsigned num_cache_p           = 2,
  parameter int unsigned axi_id_width_p        = 6,
  parameter int unsigned axi_data_width_p      = 32,
  parameter int unsigned axi_burst_len_p       = 4,
  parameter int unsigned axi_burst_type_p      = 0,
  parameter int unsigned tag_fifo_els_p        = 4
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                v_i,
  output logic                                yumi_o,
  input  logic [lg_f(num_cache_p)-1:0]        cache_id_i,
  input  logic [addr_width_p-1:0]             addr_i,
  output logic [axi_id_width_p-1:0]           axi_arid_o,
  output logic [addr_width_p-1:0]             axi_araddr_addr_o,
  output logic [lg_f(num_cache_p)-1:0]        axi_araddr_cache_id_o,
  output logic [7:0]                          axi_arlen_o,
  output logic [2:0]                          axi_arsize_o,
  output logic [1:0]                          axi_arburst_o,
  output logic [3:0]                          axi_arcache_o,
  output logic [2:0]                          axi_arprot_o,
  output logic                                axi_arlock_o,
  output logic                                axi_arvalid_o,
  input  logic                                axi_arready_i,
  input  logic [axi_id_width_p-1:0]           axi_rid_i,
  input  logic [axi_data_width_p-1:0]         axi_rdata_i,
  input  logic [1:0]                          axi_rresp_i,
  input  logic                                axi_rlast_i,
  input  logic                                axi_rvalid_i,
  output logic                                axi_rready_o,
  output logic [num_cache_p*data_width_p-1:0] dma_data_o,
  output logic [num_cache_p-1:0]              dma_data_v_o,
  input  logic [num_cache_p-1:0]              dma_data_ready_i
);

  localparam int unsigned IdW      = lg_f(num_cache_p);
  localparam int unsigned PtrW     = lg_f(tag_fifo_els_p);
  localparam int unsigned CntW     = $clog2(tag_fifo_els_p + 1);
  localparam int unsigned WordCntW = lg_f(block_size_in_words_p);
  localparam int unsigned BeatCntW = lg_f(axi_burst_len_p);

  // Tag FIFO: cache id of every outstanding AR, head owns the current R traffic.
  logic [IdW-1:0]  tag_mem_q [tag_fifo_els_p];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic            tag_v, tag_ready, tag_enq, tag_deq;
  logic [IdW-1:0]  head_id;

  logic [WordCntW-1:0]   word_cnt_q;
  logic [BeatCntW-1:0]   beat_cnt_q;
  logic                  buf_v, beat_last_word, word_hs, block_end, beat_accept, last_beat;
  logic [data_width_p-1:0] word;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(tag_fifo_els_p - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign tag_v     = (cnt_q != '0);
  assign tag_ready = (cnt_q != CntW'(tag_fifo_els_p));
  assign head_id   = tag_mem_q[rptr_q];

  assign axi_arvalid_o         = v_i & tag_ready;
  assign tag_enq               = v_i & axi_arready_i & tag_ready;
  assign yumi_o                = tag_enq;
  assign axi_arid_o            = '0;
  assign axi_araddr_addr_o     = addr_i;
  assign axi_araddr_cache_id_o = cache_id_i;
  assign axi_arlen_o           = 8'(axi_burst_len_p - 1);
  assign axi_arsize_o          = axi_size_f(axi_data_width_p / 8);
  assign axi_arburst_o         = 2'(axi_burst_type_p);
  assign axi_arcache_o         = AxiCacheDevNonBuf;
  assign axi_arprot_o          = AxiProtDefault;
  assign axi_arlock_o          = AxiLockNormal;

  assign word_hs   = buf_v & dma_data_ready_i[head_id];
  assign block_end = (word_cnt_q == WordCntW'(block_size_in_words_p - 1));
  assign tag_deq   = word_hs & block_end;
  assign last_beat = (beat_cnt_q == BeatCntW'(axi_burst_len_p - 1));

  // The last word of a block holds rready low so the next block's beat lands a cycle later.
  assign axi_rready_o = ~reset_i & tag_v & (~buf_v | (word_hs & beat_last_word & ~block_end));
  assign beat_accept  = axi_rready_o & axi_rvalid_i;

  assign dma_data_o = {num_cache_p{word}};

  always_comb begin
    dma_data_v_o = '0;
    for (int i = 0; i < num_cache_p; i++) begin
      dma_data_v_o[i] = ~reset_i & buf_v & (head_id == IdW'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (tag_enq) begin
      tag_mem_q[wptr_q] <= cache_id_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      word_cnt_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      if (tag_enq) wptr_q <= ptr_inc(wptr_q);
      if (tag_deq) rptr_q <= ptr_inc(rptr_q);
      cnt_q <= cnt_q + CntW'(tag_enq) - CntW'(tag_deq);
      if (word_hs) word_cnt_q <= block_end ? '0 : word_cnt_q + WordCntW'(1);
      if (beat_accept) beat_cnt_q <= last_beat ? '0 : beat_cnt_q + BeatCntW'(1);
    end
  end

  bsg_cache_to_axi_rx_piso #(
    .in_width_p (axi_data_width_p),
    .out_width_p(data_width_p)
  ) u_piso (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .load_i (beat_accept),
    .data_i (axi_rdata_i),
    .yumi_i (word_hs),
    .v_o    (buf_v),
    .data_o (word),
    .last_o (beat_last_word)
  );

  logic unused_r_sideband;
  assign unused_r_sideband = ^{axi_rid_i, axi_rresp_i};

  rlast_matches_beat_count_a: assert property (
    @(posedge clk_i) disable iff (reset_i) beat_accept |-> (axi_rlast_i == last_beat)
  );

endmodule

// File: tb/tb_bsg_cache_to_axi_rx.sv
// Randomized bench: AXI read slave plus a block-level scoreboard of expected cache words.
module tb_bsg_cache_to_axi_rx;

  localparam int unsigned AddrW    = 28;
  localparam int unsigned DW       = 32;
  localparam int unsigned BlockW   = 4;
  localparam int unsigned NumCache = 2;
  localparam int unsigned IdBits   = 6;
  localparam int unsigned AxiDW    = 32;
  localparam int unsigned BurstLen = 4;
  localparam int unsigned TagEls   = 4;
  localparam int unsigned WPB      = AxiDW / DW;

  logic clk = 1'b0;
  logic reset_i;
  logic v_i, yumi_o;
  logic [0:0] cache_id_i;
  logic [AddrW-1:0] addr_i;
  logic [IdBits-1:0] axi_arid_o;
  logic [AddrW-1:0] axi_araddr_addr_o;
  logic [0:0] axi_araddr_cache_id_o;
  logic [7:0] axi_arlen_o;
  logic [2:0] axi_arsize_o;
  logic [1:0] axi_arburst_o;
  logic [3:0] axi_arcache_o;
  logic [2:0] axi_arprot_o;
  logic axi_arlock_o, axi_arvalid_o, axi_arready_i;
  logic [IdBits-1:0] axi_rid_i;
  logic [AxiDW-1:0] axi_rdata_i;
  logic [1:0] axi_rresp_i;
  logic axi_rlast_i, axi_rvalid_i, axi_rready_o;
  logic [NumCache*DW-1:0] dma_data_o;
  logic [NumCache-1:0] dma_data_v_o, dma_data_ready_i;

  always #5 clk = ~clk;

  bsg_cache_to_axi_rx #(
    .addr_width_p(AddrW), .data_width_p(DW), .block_size_in_words_p(BlockW),
    .num_cache_p(NumCache), .axi_id_width_p(IdBits), .axi_data_width_p(AxiDW),
    .axi_burst_len_p(BurstLen), .axi_burst_type_p(1), .tag_fifo_els_p(TagEls)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .yumi_o(yumi_o), .cache_id_i(cache_id_i),
    .addr_i(addr_i), .axi_arid_o(axi_arid_o), .axi_araddr_addr_o(axi_araddr_addr_o),
    .axi_araddr_cache_id_o(axi_araddr_cache_id_o), .axi_arlen_o(axi_arlen_o),
    .axi_arsize_o(axi_arsize_o), .axi_arburst_o(axi_arburst_o), .axi_arcache_o(axi_arcache_o),
    .axi_arprot_o(axi_arprot_o), .axi_arlock_o(axi_arlock_o), .axi_arvalid_o(axi_arvalid_o),
    .axi_arready_i(axi_arready_i), .axi_rid_i(axi_rid_i), .axi_rdata_i(axi_rdata_i),
    .axi_rresp_i(axi_rresp_i), .axi_rlast_i(axi_rlast_i), .axi_rvalid_i(axi_rvalid_i),
    .axi_rready_o(axi_rready_o), .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o),
    .dma_data_ready_i(dma_data_ready_i)
  );

  typedef struct { int id; logic [DW-1:0] word; bit first; bit last; } exp_t;
  typedef struct { logic [AxiDW-1:0] data; logic last; } beat_t;
  exp_t  exp_q[$];
  beat_t beat_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, done_cyc = -100, outstanding = 0, issued = 0, delivered = 0;
  int req_left = 0, req_pct = 0, ar_pct = 0, rv_pct = 0, rdy_pct = 0;
  bit req_taken = 0, r_taken = 0, last_arvalid = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_block(input int id);
    logic [DW-1:0] w[BlockW];
    for (int i = 0; i < BlockW; i++) begin
      w[i] = DW'($urandom);
      exp_q.push_back('{id: id, word: w[i], first: (i == 0), last: (i == BlockW - 1)});
    end
    for (int b = 0; b < BurstLen; b++) begin
      beat_t bt;
      bt.data = '0;
      for (int k = 0; k < WPB; k++) bt.data[k*DW +: DW] = w[b*WPB + k];
      bt.last = (b == BurstLen - 1);
      beat_q.push_back(bt);
    end
  endtask

  task automatic step();
    logic [NumCache*DW-1:0] exp_data;
    int oc_next;
    @(negedge clk);
    if (req_taken) begin v_i = 1'b0; req_taken = 0; end
    if (r_taken) begin axi_rvalid_i = 1'b0; r_taken = 0; end
    if (!v_i && req_left > 0 && $urandom_range(99) < req_pct) begin
      v_i = 1'b1;
      cache_id_i = 1'($urandom_range(NumCache - 1));
      addr_i = AddrW'($urandom);
      req_left--;
    end
    axi_arready_i = ($urandom_range(99) < ar_pct);
    if (!axi_rvalid_i && beat_q.size() > 0 && $urandom_range(99) < rv_pct) begin
      axi_rvalid_i = 1'b1;
      axi_rdata_i = beat_q[0].data;
      axi_rlast_i = beat_q[0].last;
    end
    for (int i = 0; i < NumCache; i++) dma_data_ready_i[i] = ($urandom_range(99) < rdy_pct);
    #1;
    cyc++;
    oc_next = outstanding;
    last_arvalid = axi_arvalid_o;
    check_eq("arvalid", axi_arvalid_o, v_i && outstanding < TagEls);
    check_eq("yumi", yumi_o, v_i && axi_arready_i && outstanding < TagEls);
    if (outstanding == 0) check_eq("rready_idle", axi_rready_o, 0);
    if (yumi_o) begin
      check_eq("araddr", axi_araddr_addr_o, addr_i);
      check_eq("ar_cache_id", axi_araddr_cache_id_o, cache_id_i);
      check_eq("ar_len_size_burst", {axi_arlen_o, axi_arsize_o, axi_arburst_o},
               {8'(BurstLen - 1), 3'($clog2(AxiDW / 8)), 2'b01});
      check_eq("ar_consts", {axi_arid_o, axi_arcache_o, axi_arprot_o, axi_arlock_o}, 0);
      push_block(int'(cache_id_i));
      req_taken = 1;
      issued++;
      oc_next++;
    end
    if (axi_rvalid_i && axi_rready_o) begin
      void'(beat_q.pop_front());
      r_taken = 1;
    end
    if (dma_data_v_o != '0) begin
      if (exp_q.size() == 0) begin
        check_eq("dma_v_spurious", dma_data_v_o, 0);
      end else begin
        exp_data = {NumCache{exp_q[0].word}};
        check_eq("dma_v", dma_data_v_o, 64'(1) << exp_q[0].id);
        check_eq("dma_data", dma_data_o, exp_data);
        if (exp_q[0].first) check_eq("block_gap", (cyc - done_cyc) >= 2, 1);
        if (dma_data_ready_i[exp_q[0].id]) begin
          delivered++;
          if (exp_q[0].last) begin
            done_cyc = cyc;
            oc_next--;
          end
          void'(exp_q.pop_front());
        end
      end
    end
    outstanding = oc_next;
  endtask

  function automatic bit all_done();
    return req_left == 0 && !v_i && outstanding == 0 && exp_q.size() == 0;
  endfunction

  task automatic run_to_done(input string tag);
    for (int i = 0; i < 20000 && !all_done(); i++) step();
    check_eq(tag, all_done(), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1; v_i = 1'b0; axi_arready_i = 1'b0; axi_rvalid_i = 1'b0;
    dma_data_ready_i = '0;
    #1;
    check_eq("reset_rready", axi_rready_o, 0);
    check_eq("reset_dma_v", dma_data_v_o, 0);
    @(negedge clk);
    reset_i = 1'b0;
    exp_q.delete(); beat_q.delete();
    outstanding = 0; req_taken = 0; r_taken = 0; req_left = 0; done_cyc = -100;
    #1;
    check_eq("post_reset_rready", axi_rready_o, 0);
    check_eq("post_reset_dma_v", dma_data_v_o, 0);
  endtask

  initial begin
    int base;
    reset_i = 1'b1; v_i = 1'b0; cache_id_i = '0; addr_i = '0; axi_arready_i = 1'b0;
    axi_rid_i = '0; axi_rdata_i = '0; axi_rresp_i = '0; axi_rlast_i = 1'b0;
    axi_rvalid_i = 1'b0; dma_data_ready_i = '0;
    repeat (2) @(negedge clk);
    do_reset();

    // Fill the tag FIFO with no R traffic: fifth request must stall.
    req_left = 5; req_pct = 100; ar_pct = 100; rv_pct = 0; rdy_pct = 100;
    base = issued;
    repeat (12) step();
    check_eq("fill_issued", issued - base, TagEls);
    check_eq("fill_stall_arvalid", last_arvalid, 0);
    rv_pct = 100;
    run_to_done("fill_drain");
    check_eq("fill_all_issued", issued - base, 5);

    // Fully random traffic with backpressure everywhere.
    req_left = 40; req_pct = 60; ar_pct = 70; rv_pct = 60; rdy_pct = 50;
    run_to_done("random_drain");

    // Back-to-back with everything ready to stress the block boundary gap.
    req_left = 12; req_pct = 100; ar_pct = 100; rv_pct = 100; rdy_pct = 100;
    run_to_done("b2b_drain");

    // Reset in the middle of a block, then a fresh transfer.
    req_left = 1; req_pct = 100; ar_pct = 100; rv_pct = 100; rdy_pct = 100;
    base = delivered;
    for (int i = 0; i < 100 && delivered - base < 2; i++) step();
    check_eq("mid_block_progress", delivered - base, 2);
    do_reset();
    req_left = 3; req_pct = 100; ar_pct = 80; rv_pct = 80; rdy_pct = 70;
    run_to_done("after_reset_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
